// File: rtl/nmr_scan_sequencer.sv
// Multi-scan NMR pulse-sequence controller: ARM, EXCITE, DEAD, ACQ, WAIT_WR, RELAX per scan.
// All outputs are registered Moore decodes of the next state, so they line up with the state register.
module nmr_scan_sequencer #(
    parameter int CNT_W  = 32,
    parameter int SCAN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  cfg_exc_time,
    input  logic [CNT_W-1:0]  cfg_dead_time,
    input  logic [CNT_W-1:0]  cfg_acq_time,
    input  logic [CNT_W-1:0]  cfg_tr_time,
    input  logic [SCAN_W-1:0] cfg_nb_scans,
    input  logic              wr_done,
    output logic              en_gen,
    output logic              en_acq,
    output logic              rst_writer,
    output logic [SCAN_W-1:0] scan_idx,
    output logic              busy,
    output logic              done,
    output logic [31:0]       sts,
    output logic [6:0]        Leds
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_EXCITE  = 3'd2,
        S_DEAD    = 3'd3,
        S_ACQ     = 3'd4,
        S_WAIT_WR = 3'd5,
        S_RELAX   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // A programmed duration of 0 behaves as 1, so the counter load is max(n,1)-1.
    function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] n);
        return (n == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (n - CNT_W'(1));
    endfunction

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SCAN_W-1:0] r_scan;
    logic              r_aborted;
    logic [CNT_W-1:0]  r_exc_time;
    logic [CNT_W-1:0]  r_dead_time;
    logic [CNT_W-1:0]  r_acq_time;
    logic [CNT_W-1:0]  r_tr_time;
    logic [SCAN_W-1:0] r_nb_scans;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [SCAN_W-1:0] w_scan_nxt;
    logic              w_aborted_nxt;
    logic              w_run_start;
    logic              w_cnt_zero;
    logic              w_last_scan;

    logic              w_en_gen;
    logic              w_en_acq;
    logic              w_rst_writer;
    logic              w_busy;
    logic              w_done;
    logic [31:0]       w_sts;
    logic [6:0]        w_leds;

    assign w_cnt_zero  = (r_cnt == {CNT_W{1'b0}});
    assign w_last_scan = (r_scan == (r_nb_scans - SCAN_W'(1)));

    // State register, phase counter, scan index, sticky abort flag and latched configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_scan      <= {SCAN_W{1'b0}};
            r_aborted   <= 1'b0;
            r_exc_time  <= {CNT_W{1'b0}};
            r_dead_time <= {CNT_W{1'b0}};
            r_acq_time  <= {CNT_W{1'b0}};
            r_tr_time   <= {CNT_W{1'b0}};
            r_nb_scans  <= {SCAN_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_scan    <= w_scan_nxt;
            r_aborted <= w_aborted_nxt;
            if (w_run_start) begin
                r_exc_time  <= cfg_exc_time;
                r_dead_time <= cfg_dead_time;
                r_acq_time  <= cfg_acq_time;
                r_tr_time   <= cfg_tr_time;
                r_nb_scans  <= cfg_nb_scans;
            end
        end
    end

    // Next-state logic; abort outranks every other transition while a run is active.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_scan_nxt    = r_scan;
        w_aborted_nxt = r_aborted;
        w_run_start   = 1'b0;
        if (abort && (r_state != S_IDLE) && (r_state != S_DONE)) begin
            w_state_nxt   = S_IDLE;
            w_aborted_nxt = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (cfg_nb_scans != {SCAN_W{1'b0}})) begin
                        w_state_nxt   = S_ARM;
                        w_scan_nxt    = {SCAN_W{1'b0}};
                        w_aborted_nxt = 1'b0;
                        w_run_start   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_ARM: begin
                    w_state_nxt = S_EXCITE;
                    w_cnt_nxt   = phase_load(r_exc_time);
                end
                S_EXCITE: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = S_DEAD;
                        w_cnt_nxt   = phase_load(r_dead_time);
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_DEAD: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = S_ACQ;
                        w_cnt_nxt   = phase_load(r_acq_time);
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_ACQ: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = S_WAIT_WR;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_WAIT_WR: begin
                    if (wr_done) begin
                        w_state_nxt = S_RELAX;
                        w_cnt_nxt   = phase_load(r_tr_time);
                    end else begin
                        w_state_nxt = S_WAIT_WR;
                    end
                end
                S_RELAX: begin
                    if (!w_cnt_zero) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else if (w_last_scan) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ARM;
                        w_scan_nxt  = r_scan + SCAN_W'(1);
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track r_state.
    always_comb begin
        w_en_gen     = 1'b0;
        w_en_acq     = 1'b0;
        w_rst_writer = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (w_state_nxt)
            S_IDLE:    w_rst_writer = 1'b1;
            S_ARM: begin
                w_rst_writer = 1'b1;
                w_busy       = 1'b1;
            end
            S_EXCITE: begin
                w_en_gen = 1'b1;
                w_busy   = 1'b1;
            end
            S_DEAD:    w_busy = 1'b1;
            S_ACQ: begin
                w_en_acq = 1'b1;
                w_busy   = 1'b1;
            end
            S_WAIT_WR: w_busy = 1'b1;
            S_RELAX:   w_busy = 1'b1;
            S_DONE: begin
                w_rst_writer = 1'b1;
                w_done       = 1'b1;
            end
            default:   w_rst_writer = 1'b1;
        endcase
        w_sts  = {16'(w_scan_nxt), 10'd0, w_aborted_nxt, w_done, w_busy, w_state_nxt};
        w_leds = {w_done, w_busy, w_en_acq, w_en_gen, w_state_nxt};
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_gen     <= 1'b0;
            en_acq     <= 1'b0;
            rst_writer <= 1'b1;
            scan_idx   <= {SCAN_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            sts        <= 32'h0000_0000;
            Leds       <= 7'b000_0000;
        end else begin
            en_gen     <= w_en_gen;
            en_acq     <= w_en_acq;
            rst_writer <= w_rst_writer;
            scan_idx   <= w_scan_nxt;
            busy       <= w_busy;
            done       <= w_done;
            sts        <= w_sts;
            Leds       <= w_leds;
        end
    end

endmodule

// File: tb/tb_nmr_scan_sequencer.sv
// Randomized bench for nmr_scan_sequencer: each run is expanded into an expected per-cycle
// timeline of (state, scan, aborted) built from phase lengths, then compared cycle by cycle.
module tb_nmr_scan_sequencer;

    localparam int CNT_W  = 32;
    localparam int SCAN_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  cfg_exc_time;
    logic [CNT_W-1:0]  cfg_dead_time;
    logic [CNT_W-1:0]  cfg_acq_time;
    logic [CNT_W-1:0]  cfg_tr_time;
    logic [SCAN_W-1:0] cfg_nb_scans;
    logic              wr_done;
    logic              en_gen;
    logic              en_acq;
    logic              rst_writer;
    logic [SCAN_W-1:0] scan_idx;
    logic              busy;
    logic              done;
    logic [31:0]       sts;
    logic [6:0]        Leds;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] sc;
        logic        ab;
    } ent_t;

    ent_t tl[$];
    ent_t last_e;

    always #5 clk = ~clk;

    nmr_scan_sequencer #(.CNT_W(CNT_W), .SCAN_W(SCAN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_exc_time(cfg_exc_time), .cfg_dead_time(cfg_dead_time),
        .cfg_acq_time(cfg_acq_time), .cfg_tr_time(cfg_tr_time),
        .cfg_nb_scans(cfg_nb_scans), .wr_done(wr_done),
        .en_gen(en_gen), .en_acq(en_acq), .rst_writer(rst_writer),
        .scan_idx(scan_idx), .busy(busy), .done(done), .sts(sts), .Leds(Leds)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_ent(input ent_t e);
        logic dn;
        logic bz;
        dn = (e.st == 3'd7);
        bz = (e.st != 3'd0) && (e.st != 3'd7);
        check_val("sts", sts, {e.sc, 10'd0, e.ab, dn, bz, e.st});
        check_val("leds", {25'd0, Leds}, {25'd0, dn, bz, (e.st == 3'd4), (e.st == 3'd2), e.st});
        check_val("en_gen", {31'd0, en_gen}, {31'd0, (e.st == 3'd2)});
        check_val("en_acq", {31'd0, en_acq}, {31'd0, (e.st == 3'd4)});
        check_val("rst_writer", {31'd0, rst_writer},
                  {31'd0, (e.st == 3'd0) || (e.st == 3'd1) || (e.st == 3'd7)});
        check_val("busy", {31'd0, busy}, {31'd0, bz});
        check_val("done", {31'd0, done}, {31'd0, dn});
        check_val("scan_idx", {16'd0, scan_idx}, {16'd0, e.sc});
    endtask

    function automatic int max1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic set_cfg_rand();
        cfg_exc_time  = CNT_W'($urandom_range(0, 200));
        cfg_dead_time = CNT_W'($urandom_range(0, 200));
        cfg_acq_time  = CNT_W'($urandom_range(0, 200));
        cfg_tr_time   = CNT_W'($urandom_range(0, 200));
        cfg_nb_scans  = SCAN_W'($urandom_range(0, 9));
    endtask

    // abort_mode: 0 none, 1 abort during ACQ of scan 1, 2 random abort, 3 random reset
    task automatic do_run(input int e, input int d, input int a, input int t, input int n,
                          input int w_fix, input int abort_mode, input bit cfg_chg);
        int   idx;
        int   w;
        int   h;
        int   nrun;
        ent_t x;
        tl.delete();
        for (int s = 0; s < n; s++) begin
            x.sc = 16'(s);
            x.ab = 1'b0;
            x.st = 3'd1; tl.push_back(x);
            x.st = 3'd2; repeat (max1(e)) tl.push_back(x);
            x.st = 3'd3; repeat (max1(d)) tl.push_back(x);
            x.st = 3'd4; repeat (max1(a)) tl.push_back(x);
            w = (w_fix > 0) ? w_fix : int'($urandom_range(1, 4));
            x.st = 3'd5; repeat (w) tl.push_back(x);
            x.st = 3'd6; repeat (max1(t)) tl.push_back(x);
        end
        nrun = tl.size();
        h = int'($urandom_range(0, 3));
        x.st = 3'd7; x.sc = 16'(n - 1); x.ab = 1'b0;
        repeat (h + 1) tl.push_back(x);
        x.st = 3'd0; tl.push_back(x);

        idx = -1;
        case (abort_mode)
            1: begin
                for (int i = 0; i < nrun; i++)
                    if (idx < 0 && tl[i].st == 3'd4 && tl[i].sc == 16'd1) idx = i + 3;
            end
            2, 3: idx = int'($urandom_range(0, nrun - 1));
            default: idx = -1;
        endcase
        if (idx >= 0) begin
            x = tl[idx];
            while (tl.size() > idx + 1) void'(tl.pop_back());
            x.st = 3'd0;
            if (abort_mode == 3) begin
                x.sc = 16'd0;
                x.ab = 1'b0;
            end else begin
                x.ab = 1'b1;
            end
            tl.push_back(x);
        end

        cfg_exc_time  = CNT_W'(e);
        cfg_dead_time = CNT_W'(d);
        cfg_acq_time  = CNT_W'(a);
        cfg_tr_time   = CNT_W'(t);
        cfg_nb_scans  = SCAN_W'(n);
        start   = 1'b1;
        abort   = 1'b0;
        rst     = 1'b0;
        wr_done = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check_ent(tl[0]);
        for (int k = 0; k < tl.size() - 1; k++) begin
            if (cfg_chg) set_cfg_rand();
            abort = (k == idx) && (abort_mode != 3);
            rst   = (k == idx) && (abort_mode == 3);
            if (tl[k].st == 3'd5) wr_done = (tl[k + 1].st == 3'd6);
            else                  wr_done = 1'($urandom_range(0, 1));
            if (tl[k].st == 3'd7) start = (tl[k + 1].st == 3'd7);
            else                  start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check_ent(tl[k + 1]);
        end
        abort  = 1'b0;
        rst    = 1'b0;
        start  = 1'b0;
        last_e = tl[tl.size() - 1];
        repeat (2) begin
            @(posedge clk); #1;
            check_ent(last_e);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; wr_done = 1'b0;
        cfg_exc_time = '0; cfg_dead_time = '0; cfg_acq_time = '0;
        cfg_tr_time = '0; cfg_nb_scans = '0;
        last_e = '0;
        repeat (3) begin
            @(posedge clk); #1;
            check_ent(last_e);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check_ent(last_e);

        // nominal run with configuration churn mid-run
        do_run(12, 4, 20, 8, 3, 5, 0, 1'b1);
        // zero durations, writer always ready
        do_run(0, 0, 0, 0, 2, 1, 0, 1'b0);
        // abort during ACQ of scan 1, then a fresh run must clear the flag
        do_run(12, 4, 20, 8, 3, 5, 1, 1'b0);
        do_run(3, 2, 5, 1, 2, 0, 0, 1'b1);

        // zero scan count must not start a run
        cfg_nb_scans = 16'd0; cfg_exc_time = 32'd5; start = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check_ent(last_e);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check_ent(last_e);

        for (int r = 0; r < 30; r++) begin
            int m;
            m = int'($urandom_range(0, 5));
            do_run(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   int'($urandom_range(1, 4)), 0,
                   (m == 4) ? 2 : ((m == 5) ? 3 : 0), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
